// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the two-requester bitwise logic unit arbiter.
package logic_unit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_NOT_A = 3'b110,
        OP_PASS_A = 3'b111
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise operation unit; one instance is shared by both requesters.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Opcode decode to the bitwise result
    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_XNOR:   y = ~(a ^ b);
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter between two requesters feeding a single-entry result slot
// through a shared logic unit; one result per cycle when the consumer keeps up.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [15:0]      done_cnt
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic [15:0]      done_cnt_q, done_cnt_d;

    logic             slot_free_s;
    logic             consume_s;
    logic             gnt_s;
    logic             gnt_id_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [WIDTH-1:0] lu_y_s;

    // Grant selection; rst_n gates it so nothing is accepted while reset is held
    always_comb begin
        consume_s   = (state_q == ST_FULL) && res_ready;
        slot_free_s = (state_q == ST_EMPTY) || res_ready;
        gnt_s       = rst_n && slot_free_s && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            gnt_id_s = ptr_q;
        end else begin
            gnt_id_s = req1_valid;
        end
        req0_ready = gnt_s && !gnt_id_s;
        req1_ready = gnt_s && gnt_id_s;
    end

    // Operand mux in front of the shared logic unit
    always_comb begin
        if (gnt_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op (sel_op_s),
        .a  (sel_a_s),
        .b  (sel_b_s),
        .y  (lu_y_s)
    );

    // Next-state for slot, pointer, result registers and consume counter
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        done_cnt_d = done_cnt_q;
        if (consume_s) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end else begin
            done_cnt_d = done_cnt_q;
        end
        if (gnt_s) begin
            state_d    = ST_FULL;
            res_data_d = lu_y_s;
            res_id_d   = gnt_id_s;
            ptr_d      = ~gnt_id_s;
        end else if (consume_s) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            done_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a result scoreboard.
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_data;
    logic [15:0] done_cnt;

    int          total;
    int          bad;
    logic [15:0] exp_done;
    logic [31:0] sb_data[$];
    logic        sb_id[$];
    int          g;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a ^ b);
            3'b100:  return ~(a & b);
            3'b101:  return ~(a | b);
            3'b110:  return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; observes the cycle at posedge+4, then crosses the next edge.
    task automatic tick(input int exp_gnt, input logic exp_valid);
        #3;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_gnt == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_gnt == 1});
        chk("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
        chk("done_cnt", {16'd0, done_cnt}, {16'd0, exp_done});
        if (res_valid && res_ready) begin
            if (sb_data.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("res_data", res_data, sb_data.pop_front());
                chk("res_id", {31'd0, res_id}, {31'd0, sb_id.pop_front()});
                exp_done = exp_done + 16'd1;
            end
        end else if (res_valid && sb_data.size() != 0) begin
            chk("hold_data", res_data, sb_data[0]);
            chk("hold_id", {31'd0, res_id}, {31'd0, sb_id[0]});
        end
        if (exp_gnt == 0) begin
            sb_data.push_back(ref_op(req0_op, req0_a, req0_b));
            sb_id.push_back(1'b0);
        end else if (exp_gnt == 1) begin
            sb_data.push_back(ref_op(req1_op, req1_a, req1_b));
            sb_id.push_back(1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; exp_done = 16'd0;
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = 32'd0; req1_b = 32'd0;

        // Reset state, with both requesters valid
        #2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", {31'd0, res_id}, 32'd0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single XNOR from req0, accepted at the first edge after reset
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'h0000000F; req0_b = 32'h00000005;
        res_ready = 1'b1;
        chk("xnor_ref", ref_op(req0_op, req0_a, req0_b), 32'hFFFFFFF5);
        tick(0, 1'b0);
        req0_valid = 1'b0;
        tick(-1, 1'b1);
        tick(-1, 1'b0);

        // req1 alone (pointer was 1), then both valid alternate 0,1,0,1
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'h12340000; req1_b = 32'h00005678;
        tick(1, 1'b0);
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'hDEADBEEF; req0_b = 32'h0F0F0F0F;
        req1_op = 3'b100; req1_a = 32'hCAFEF00D;
        tick(0, 1'b1);
        tick(1, 1'b1);
        req0_op = 3'b101;
        tick(0, 1'b1);
        req1_op = 3'b110;
        tick(1, 1'b1);

        // Stall five cycles while both valid; the granted operands change meanwhile
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req1_a = req1_a + 32'h01010101;
            req1_op = 3'(i);
            tick(-1, 1'b1);
        end
        res_ready = 1'b1;
        tick(0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(-1, 1'b1);
        tick(-1, 1'b0);

        // Opcode sweep through req0
        req0_valid = 1'b1; req0_a = 32'hA5A5A5A5; req0_b = 32'h0F0F0F0F;
        for (int op = 0; op < 8; op++) begin
            req0_op = 3'(op);
            tick(0, op != 0);
        end
        req0_valid = 1'b0;
        tick(-1, 1'b1);
        tick(-1, 1'b0);

        // Asynchronous reset while FULL
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 32'h55AA55AA; res_ready = 1'b0;
        tick(0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        chk("full_before_rst", {31'd0, res_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_res_valid", {31'd0, res_valid}, 32'd0);
        chk("async_res_data", res_data, 32'd0);
        chk("async_done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("async_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("async_req1_ready", {31'd0, req1_ready}, 32'd0);
        sb_data.delete();
        sb_id.delete();
        exp_done = 16'd0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        req0_op = 3'b000; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
        req1_op = 3'b010; req1_a = 32'h13579BDF; req1_b = 32'h2468ACE0;
        tick(0, 1'b0);

        // Continuous traffic until done_cnt wraps
        g = 1;
        for (int i = 0; i < 65535; i++) begin
            tick(g, 1'b1);
            g = 1 - g;
        end
        chk("cnt_ffff", {16'd0, done_cnt}, 32'h0000FFFF);
        tick(g, 1'b1);
        chk("cnt_wrap", {16'd0, done_cnt}, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
